regfile_write_ctrl: RTL and testbench
=====================================

# regfile_write_ctrl

Write-port controller for the 8×8-bit register file. It shares the file's single write port between two requesters using round-robin arbitration with valid/ready handshakes. It runs a zero-fill sweep of r1..r7 after reset and on demand, and discards writes to the hardwired-zero r0, counting each one. It sits between the execute/writeback logic (requester 0), the load/debug path (requester 1) and the register file's write_enable/write_address/write_data inputs.

## Interface
- DATA_W, 8, data width of one register
- ADDR_W, 3, register address width
- NUM_REGS, 8, register count; r0 is hardwired zero
- clock_reg  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  ADDR_W  requester 0 target register
- req0_data  input  DATA_W  requester 0 write data
- req0_ready  output  1  requester 0 transfer accepted this cycle (combinational)
- req1_valid / req1_addr / req1_data / req1_ready  same as requester 0, for requester 1
- clear_req  input  1  single-cycle pulse requesting a zero-fill sweep
- busy  output  1  high while a sweep is in progress
- we_out  output  1  register file write enable (registered)
- wa_out  output  ADDR_W  register file write address (registered)
- wd_out  output  DATA_W  register file write data (registered)
- drop_count  output  8  number of writes discarded because they targeted r0; saturates at 255

## Operation
- States:
  - CLEAR: sweeping; sweep counter cnt covers 1..NUM_REGS-1.
  - RUN: arbitrating requesters.
- Reset (reset=0):
  - state=CLEAR, cnt=1, last_grant=1 (so requester 0 wins the first tie).
  - we_out=0, wa_out=0, wd_out=0, drop_count=0.
  - busy=1.
- CLEAR, on each edge:
  - we_out<=1, wa_out<=cnt, wd_out<=0, then cnt<=cnt+1.
  - On the edge where cnt==NUM_REGS-1: state<=RUN and cnt<=1.
  - clear_req is ignored in CLEAR.
  - Both ready outputs are 0.
- RUN, readiness:
  - reqN_ready=1 only if state==RUN, clear_req==0, reqN_valid==1, and N is the arbiter winner.
- RUN, arbitration:
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester that was not last_grant wins.
  - last_grant updates only on an accepted transfer.
- RUN, accepted transfer to addr≠0: we_out<=1, wa_out<=addr, wd_out<=data on the same edge.
- RUN, accepted transfer to addr==0:
  - Request is accepted (ready=1) and last_grant updates.
  - we_out<=0 and drop_count<=drop_count+1, saturating at 255.
- RUN, no transfer: we_out<=0; wa_out and wd_out hold their previous values.
- RUN, clear_req=1: state<=CLEAR, cnt<=1. No transfer in that cycle, so we_out<=0.
- busy = (state==CLEAR), decoded combinationally from state.

## Timing
- Handshake:
  - A transfer occurs at an edge where valid&&ready.
  - A requester holds valid, addr and data stable until that edge.
  - ready never depends on reqN_data or reqN_addr.
- Latency: the write strobe appears on we_out/wa_out/wd_out in the cycle after the accepting edge. The register file commits it on the following edge.
- Throughput: one write per cycle. With both requesters continuously valid, grants alternate 0,1,0,1…
- Sweep: exactly NUM_REGS-1 = 7 consecutive cycles of we_out=1 with wa_out=1..7. busy deasserts after the 7th edge, and the first grant can occur on the 8th edge.
- Reset mid-sweep or mid-transfer:
  - Outputs clear asynchronously and the sweep restarts from cnt=1.
  - A request pending at reset is not accepted and must be re-presented.
- A request targeting r0 never produces we_out=1.

## Structure
- Package regfile_ctrl_pkg holds:
  - the state enum {CLEAR, RUN};
  - DATA_W, ADDR_W and NUM_REGS defaults;
  - the DROP_MAX=255 constant.
- Sub-module rr_arbiter2: two-input round-robin arbiter with request inputs, an enable input and a last_grant register, producing a one-hot grant. It is instantiated once.
- The top level holds the FSM, the sweep counter, the output registers and drop_count.

## Test plan
- Reset release, no requests → we_out=1 for 7 cycles with wa_out=1,2,…,7 and wd_out=0; busy=1 during the sweep, then busy=0 and we_out=0.
- After the sweep, req0 writes 0x5A to r3 → req0_ready=1 on the first RUN cycle; next cycle we_out=1, wa_out=3, wd_out=0x5A.
- req0 (r2, 0x11) and req1 (r4, 0x22) both held valid for 4 cycles → grants 0,1,0,1, with wa_out/wd_out following 2/0x11, 4/0x22, 2/0x11, 4/0x22.
- req1 writes 0xFF to r0 300 times → each request accepted, we_out stays 0, drop_count reaches 255 and holds.
- clear_req pulsed in the same cycle as req0_valid → req0_ready=0, busy=1 from the next cycle, a full 7-cycle sweep runs, then req0 is accepted.
- reset asserted at sweep step wa_out=4 → outputs go to 0 immediately; after release the sweep restarts at wa_out=1 and drop_count=0.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file write-port controller.
package regfile_ctrl_pkg;

    localparam int unsigned DATA_W_DEFAULT   = 8;
    localparam int unsigned ADDR_W_DEFAULT   = 3;
    localparam int unsigned NUM_REGS_DEFAULT = 8;

    // Saturation point of the r0 drop counter.
    localparam int unsigned DROP_MAX = 255;

    typedef enum logic [0:0] {
        CLEAR,
        RUN
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. When both request, the input not granted
// last time wins. last_grant only moves when a grant is actually issued.
module rr_arbiter2 (
    input  logic       clock_reg,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_grant_q, last_grant_d;

    // One-hot grant and the next value of the fairness pointer.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
        last_grant_d = last_grant_q;
        if (grant[1]) begin
            last_grant_d = 1'b1;
        end else if (grant[0]) begin
            last_grant_d = 1'b0;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Write-port controller for the register file: zero-fill sweep of r1..r7,
// round-robin sharing of the write port, and counting of discarded r0 writes.
module regfile_write_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic              clock_reg,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clear_req,
    output logic              busy,
    output logic              we_out,
    output logic [ADDR_W-1:0] wa_out,
    output logic [DATA_W-1:0] wd_out,
    output logic [7:0]        drop_count
);

    localparam logic [ADDR_W-1:0] CntFirst = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CntLast  = ADDR_W'(NUM_REGS - 1);
    localparam logic [7:0]        DropSat  = 8'(DROP_MAX);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [7:0]        drop_q, drop_d;

    logic [1:0]        grant;
    logic              arb_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // A clear request pre-empts arbitration in the cycle it is seen.
    assign arb_en = (state_q == RUN) && !clear_req;

    rr_arbiter2 u_arb (
        .clock_reg (clock_reg),
        .reset     (reset),
        .enable    (arb_en),
        .req       ({req1_valid, req0_valid}),
        .grant     (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign sel_addr   = grant[1] ? req1_addr : req0_addr;
    assign sel_data   = grant[1] ? req1_data : req0_data;

    assign busy       = (state_q == CLEAR);
    assign we_out     = we_q;
    assign wa_out     = wa_q;
    assign wd_out     = wd_q;
    assign drop_count = drop_q;

    // Next-state: sweep stepping, accepted transfers and r0 drop counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        drop_d  = drop_q;
        unique case (state_q)
            CLEAR: begin
                we_d = 1'b1;
                wa_d = cnt_q;
                wd_d = '0;
                if (cnt_q == CntLast) begin
                    state_d = RUN;
                    cnt_d   = CntFirst;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = CntFirst;
                end else if (|grant) begin
                    if (sel_addr != '0) begin
                        we_d = 1'b1;
                        wa_d = sel_addr;
                        wd_d = sel_data;
                    end else if (drop_q != DropSat) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = CntFirst;
            end
        endcase
    end

    // All controller state, cleared asynchronously into a fresh sweep.
    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            cnt_q   <= CntFirst;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Self-checking bench for regfile_write_ctrl: directed vector table, drop
// saturation, reset mid-sweep, then randomized traffic against a model.
module tb_regfile_write_ctrl;

    logic       clock_reg = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid, clear_req;
    logic [2:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, busy, we_out;
    logic [2:0] wa_out;
    logic [7:0] wd_out;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clock_reg = ~clock_reg;

    regfile_write_ctrl dut (
        .clock_reg  (clock_reg),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .clear_req  (clear_req),
        .busy       (busy),
        .we_out     (we_out),
        .wa_out     (wa_out),
        .wd_out     (wd_out),
        .drop_count (drop_count)
    );

    typedef struct {
        logic       v0;
        logic [2:0] a0;
        logic [7:0] d0;
        logic       v1;
        logic [2:0] a1;
        logic [7:0] d1;
        logic       clr;
        logic       r0;
        logic       r1;
        logic       bsy;
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [7:0] drop;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                                input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                                input logic clr, input logic r0, input logic r1,
                                input logic bsy, input logic we, input logic [2:0] wa,
                                input logic [7:0] wd, input logic [7:0] drop);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1; v.clr = clr;
        v.r0 = r0; v.r1 = r1; v.bsy = bsy; v.we = we; v.wa = wa; v.wd = wd; v.drop = drop;
        return v;
    endfunction

    task automatic drive(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                         input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                         input logic clr);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        clear_req  = clr;
    endtask

    // Starts at a negedge, ends at the next negedge.
    task automatic run_vec(input vec_t v, input string tag);
        drive(v.v0, v.a0, v.d0, v.v1, v.a1, v.d1, v.clr);
        #1;
        chk({tag, "_ready0"}, req0_ready, v.r0);
        chk({tag, "_ready1"}, req1_ready, v.r1);
        chk({tag, "_busy"}, busy, v.bsy);
        @(posedge clock_reg);
        #1;
        chk({tag, "_we"}, we_out, v.we);
        chk({tag, "_wa"}, wa_out, v.wa);
        chk({tag, "_wd"}, wd_out, v.wd);
        chk({tag, "_drop"}, drop_count, v.drop);
        @(negedge clock_reg);
    endtask

    // Reference model state, expressed as sweep position and write history.
    int m_in_sweep, m_pos, m_last, m_we, m_wa, m_wd, m_drop;

    task automatic model_reset();
        m_in_sweep = 1; m_pos = 1; m_last = 1;
        m_we = 0; m_wa = 0; m_wd = 0; m_drop = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         hit;
        bit         p0, p1, clr;
        logic [2:0] a0, a1;
        logic [7:0] d0, d1;
        int         win, a, d;

        // Directed vectors: sweep, first write, alternation, clear, r0 drop.
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3'(i + 1), 8'h00, 0));
        tbl.push_back(mk(1, 3, 8'h5A, 0, 0, 0, 0, 1, 0, 0, 1, 3, 8'h5A, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 8'h33, 0, 0, 1, 0, 1, 5, 8'h33, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 8'h33, 0));
        for (int i = 0; i < 2; i++) begin
            tbl.push_back(mk(1, 2, 8'h11, 1, 4, 8'h22, 0, 1, 0, 0, 1, 2, 8'h11, 0));
            tbl.push_back(mk(1, 2, 8'h11, 1, 4, 8'h22, 0, 0, 1, 0, 1, 4, 8'h22, 0));
        end
        tbl.push_back(mk(1, 6, 8'h77, 0, 0, 0, 1, 0, 0, 0, 0, 4, 8'h22, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1, 6, 8'h77, 0, 0, 0, 0, 0, 0, 1, 1, 3'(i + 1), 8'h00, 0));
        tbl.push_back(mk(1, 6, 8'h77, 0, 0, 0, 0, 1, 0, 0, 1, 6, 8'h77, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'hFF, 0, 0, 1, 0, 0, 6, 8'h77, 1));

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_we", we_out, 1'b0);
        chk("rst_wa", wa_out, 3'd0);
        chk("rst_wd", wd_out, 8'd0);
        chk("rst_drop", drop_count, 8'd0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        @(negedge clock_reg);
        reset = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // r0 writes: always accepted, never strobed, counter saturates.
        for (int i = 0; i < 300; i++) begin
            drive(0, 0, 0, 1, 0, 8'hFF, 0);
            #1;
            chk("drop_ready1", req1_ready, 1'b1);
            @(posedge clock_reg);
            #1;
            chk("drop_we", we_out, 1'b0);
            chk("drop_cnt", drop_count, ((i + 2) > 255) ? 255 : (i + 2));
            @(negedge clock_reg);
        end
        chk("drop_final", drop_count, 8'd255);

        // Reset asserted while the sweep is writing r4.
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clock_reg);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            @(posedge clock_reg);
            #1;
            if (we_out === 1'b1 && wa_out === 3'd4) hit = 1;
            else @(negedge clock_reg);
        end
        chk("midsweep_reached_wa4", hit, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst_we", we_out, 1'b0);
        chk("midrst_wa", wa_out, 3'd0);
        chk("midrst_wd", wd_out, 8'd0);
        chk("midrst_drop", drop_count, 8'd0);
        chk("midrst_busy", busy, 1'b1);
        @(negedge clock_reg);
        reset = 1'b1;
        for (int i = 0; i < 7; i++)
            run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3'(i + 1), 8'h00, 0), "resweep");

        // Randomized traffic against the reference model.
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clock_reg);
        reset = 1'b1;
        p0 = 0; p1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!p0) begin
                p0 = 1'($urandom_range(0, 1));
                a0 = 3'($urandom_range(0, 7));
                d0 = 8'($urandom);
            end
            if (!p1) begin
                p1 = 1'($urandom_range(0, 1));
                a1 = 3'($urandom_range(0, 7));
                d1 = 8'($urandom);
            end
            clr = ($urandom_range(0, 39) == 0);
            drive(p0, a0, d0, p1, a1, d1, clr);

            win = -1;
            if (!m_in_sweep && !clr) begin
                if (p0 && p1) win = (m_last == 0) ? 1 : 0;
                else if (p0) win = 0;
                else if (p1) win = 1;
            end
            #1;
            chk("rnd_ready0", req0_ready, win == 0);
            chk("rnd_ready1", req1_ready, win == 1);
            chk("rnd_busy", busy, m_in_sweep != 0);
            @(posedge clock_reg);
            if (m_in_sweep) begin
                m_we = 1; m_wa = m_pos; m_wd = 0;
                m_pos++;
                if (m_pos == 8) m_in_sweep = 0;
            end else if (clr) begin
                m_in_sweep = 1; m_pos = 1; m_we = 0;
            end else if (win >= 0) begin
                m_last = win;
                a = (win == 1) ? int'(a1) : int'(a0);
                d = (win == 1) ? int'(d1) : int'(d0);
                if (a == 0) begin
                    m_we = 0;
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_we = 1; m_wa = a; m_wd = d;
                end
            end else begin
                m_we = 0;
            end
            #1;
            chk("rnd_we", we_out, m_we);
            chk("rnd_wa", wa_out, m_wa);
            chk("rnd_wd", wd_out, m_wd);
            chk("rnd_drop", drop_count, m_drop);
            if (win == 0) p0 = 0;
            if (win == 1) p1 = 0;
            @(negedge clock_reg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
